// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver: row-multiplexed LED array scanner with per-frame snapshot, blanking and PWM
module led_matrix_scan_driver #(
    parameter int ROWS           = 4,
    parameter int COLS           = 8,
    parameter int TICKS_PER_ROW  = 1040,
    parameter int BLANK_TICKS    = 16,
    parameter bit COL_ACTIVE_LOW = 1'b0,
    parameter bit ROW_ACTIVE_LOW = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst,
    input  logic [31:0]     pattern_i,
    input  logic            enable_i,
    input  logic [3:0]      brightness_i,
    output logic [ROWS-1:0] row_o,
    output logic [COLS-1:0] col_o,
    output logic            frame_start_o
);
    localparam int DRIVE_TICKS = TICKS_PER_ROW - BLANK_TICKS;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(TICKS_PER_ROW + 1);

    if (ROWS * COLS != 32) begin : g_bad_geometry
        $error("ROWS*COLS must equal 32");
    end
    if (BLANK_TICKS < 1 || DRIVE_TICKS <= 0 || DRIVE_TICKS % 16 != 0) begin : g_bad_timing
        $error("BLANK_TICKS must be >=1 and DRIVE_TICKS a positive multiple of 16");
    end

    typedef enum logic [1:0] {IDLE, LATCH, BLANK, DRIVE} state_t;

    state_t          state, state_n;
    logic [RW-1:0]   row_idx, row_idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [31:0]     frame_buf;
    logic [3:0]      bright;
    logic [31:0]     duty_ticks;
    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col_n;

    // Next state and counters; dropping enable abandons the frame from any active state
    always_comb begin
        state_n   = state;
        row_idx_n = row_idx;
        cnt_n     = cnt;
        if (state != IDLE && !enable_i) begin
            state_n   = IDLE;
            row_idx_n = '0;
            cnt_n     = '0;
        end else begin
            unique case (state)
                IDLE:  state_n = enable_i ? LATCH : IDLE;
                LATCH: begin
                    state_n   = BLANK;
                    row_idx_n = '0;
                    cnt_n     = '0;
                end
                BLANK: begin
                    state_n = (cnt == CW'(BLANK_TICKS - 1)) ? DRIVE : BLANK;
                    cnt_n   = (cnt == CW'(BLANK_TICKS - 1)) ? '0 : cnt + CW'(1);
                end
                DRIVE: begin
                    if (cnt == CW'(DRIVE_TICKS - 1)) begin
                        cnt_n     = '0;
                        state_n   = (row_idx == RW'(ROWS - 1)) ? LATCH : BLANK;
                        row_idx_n = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output values for the coming cycle; column data is gated off once the PWM on-time expires
    always_comb begin
        duty_ticks = ((32'(bright) + 32'd1) * 32'(DRIVE_TICKS)) >> 4;
        row_n      = (state_n == DRIVE) ? ROWS'(1) << row_idx_n : '0;
        col_n      = (state_n == DRIVE && 32'(cnt_n) < duty_ticks) ? frame_buf[row_idx_n * COLS +: COLS] : '0;
    end

    // State, frame snapshot and registered outputs with polarity applied
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            row_idx       <= '0;
            cnt           <= '0;
            frame_buf     <= '0;
            bright        <= '0;
            row_o         <= {ROWS{ROW_ACTIVE_LOW}};
            col_o         <= {COLS{COL_ACTIVE_LOW}};
            frame_start_o <= 1'b0;
        end else begin
            state         <= state_n;
            row_idx       <= row_idx_n;
            cnt           <= cnt_n;
            frame_buf     <= (state == LATCH) ? pattern_i : frame_buf;
            bright        <= (state == LATCH) ? brightness_i : bright;
            row_o         <= ROW_ACTIVE_LOW ? ~row_n : row_n;
            col_o         <= COL_ACTIVE_LOW ? ~col_n : col_n;
            frame_start_o <= (state_n == LATCH);
        end
    end
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// tb_led_matrix_scan_driver: scoreboard bench for active-high and active-low scan driver instances
module tb_led_matrix_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pat = '0;
    logic        en = 1'b0;
    logic [3:0]  br = '0;
    logic [3:0]  row_a, row_b;
    logic [7:0]  col_a, col_b;
    logic        fs_a, fs_b;
    logic [12:0] q[$];
    logic [12:0] e;
    int          n_checks = 0;
    int          n_err = 0;

    led_matrix_scan_driver #(.TICKS_PER_ROW(36), .BLANK_TICKS(4)) dut_hi (
        .clk_i(clk), .rst(rst), .pattern_i(pat), .enable_i(en), .brightness_i(br),
        .row_o(row_a), .col_o(col_a), .frame_start_o(fs_a)
    );

    led_matrix_scan_driver #(.TICKS_PER_ROW(36), .BLANK_TICKS(4), .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b1)) dut_lo (
        .clk_i(clk), .rst(rst), .pattern_i(pat), .enable_i(en), .brightness_i(br),
        .row_o(row_b), .col_o(col_b), .frame_start_o(fs_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got fs/row/col=%h required %h", name, $time, got, exp);
        end
    endtask

    // Expected {frame_start, row, col} for cycle i of a frame (0 = LATCH, then 4 blank + 32 drive per row)
    function automatic logic [12:0] fexp(input logic [31:0] p, input int b, input int i);
        int j, r, t;
        logic [7:0] c;
        if (i == 0) return 13'h1000;
        j = i - 1;
        r = j / 36;
        t = j % 36;
        if (t < 4) return 13'h0000;
        c = (t - 4 < 2 * (b + 1)) ? p[r*8 +: 8] : 8'h00;
        return {1'b0, 4'(1 << r), c};
    endfunction

    task automatic tick(input logic [12:0] x);
        @(posedge clk);
        #1;
        q.push_back(x);
    endtask

    task automatic frame_part(input logic [31:0] p, input int b, input int from, input int to);
        for (int i = from; i <= to; i++) tick(fexp(p, b, i));
    endtask

    // Monitor: compares both instances each cycle against the queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("hi_out", {fs_a, row_a, col_a}, e);
            chk("lo_out", {fs_b, row_b, col_b}, {e[12], ~e[11:0]});
        end
    end

    initial begin
        repeat (3) tick(13'h0);
        rst = 1'b0;
        repeat (3) tick(13'h0);
        pat = 32'hA53C0F81;
        br  = 4'd15;
        en  = 1'b1;
        frame_part(32'hA53C0F81, 15, 0, 10);
        @(negedge clk);
        #1;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("async_rst_hi", {fs_a, row_a, col_a}, 13'h0000);
        chk("async_rst_lo", {fs_b, row_b, col_b}, 13'h0FFF);
        tick(13'h0);
        rst = 1'b0;
        repeat (4) tick(13'h0);
        en = 1'b1;
        frame_part(32'hA53C0F81, 15, 0, 45);
        pat = 32'hFFFFFFFF;
        frame_part(32'hA53C0F81, 15, 46, 144);
        frame_part(32'hFFFFFFFF, 15, 0, 60);
        br = 4'd7;
        frame_part(32'hFFFFFFFF, 15, 61, 144);
        frame_part(32'hFFFFFFFF, 7, 0, 100);
        br  = 4'd0;
        pat = 32'h12345678;
        frame_part(32'hFFFFFFFF, 7, 101, 144);
        frame_part(32'h12345678, 0, 0, 50);
        pat = 32'hA53C0F81;
        br  = 4'd15;
        frame_part(32'h12345678, 0, 51, 144);
        frame_part(32'hA53C0F81, 15, 0, 80);
        en = 1'b0;
        repeat (5) tick(13'h0);
        en = 1'b1;
        frame_part(32'hA53C0F81, 15, 0, 144);
        en = 1'b0;
        repeat (3) tick(13'h0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
